// File: rtl/gpu_pkg.sv
// Types, widths and small helpers shared by the triangle setup stage.
// Vertex coordinates are 12.4 unsigned. Edge A/B are 12.4 signed and C is 24.8 signed.
package gpu_pkg;

    localparam int COORD_W    = 16;
    localparam int COORD_FRAC = 4;
    localparam int EDGE_AB_W  = 17;
    localparam int EDGE_C_W   = 33;
    localparam int PROD_W     = 32;
    localparam int Z_W        = 25;
    localparam int COLOR_W    = 32;
    localparam int INV_AREA_W = 16;
    localparam int PIX_W      = 10;
    localparam int BOX_W      = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BBOX,
        ST_E0,
        ST_E1,
        ST_E2,
        ST_EMIT
    } setup_state_e;

    typedef struct packed {
        logic [2:0][COORD_W-1:0]  x;
        logic [2:0][COORD_W-1:0]  y;
        logic [2:0][Z_W-1:0]      z;
        logic [2:0][COLOR_W-1:0]  color;
        logic [INV_AREA_W-1:0]    inv_area;
    } tri_entry_t;

    function automatic logic [COORD_W-1:0] min3(input logic [2:0][COORD_W-1:0] v);
        logic [COORD_W-1:0] m;
        m = (v[0] < v[1]) ? v[0] : v[1];
        return (v[2] < m) ? v[2] : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [2:0][COORD_W-1:0] v);
        logic [COORD_W-1:0] m;
        m = (v[0] > v[1]) ? v[0] : v[1];
        return (v[2] > m) ? v[2] : m;
    endfunction

endpackage

// File: rtl/tri_queue.sv
// Circular FIFO of triangle entries. A push is dropped when full. A pop is ignored when empty.
module tri_queue
    import gpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  tri_entry_t                   din_i,
    input  logic                         pop_i,
    output tri_entry_t                   dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    tri_entry_t        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: queues incoming triangles, clips a pixel bounding box, and computes
// three edge functions with one shared multiplier pair before handing off to the rasterizer.
module triangle_setup
    import gpu_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tri_valid,
    input  logic [2:0][COORD_W-1:0]        tri_x,
    input  logic [2:0][COORD_W-1:0]        tri_y,
    input  logic [2:0][Z_W-1:0]            tri_z,
    input  logic [2:0][COLOR_W-1:0]        tri_color,
    input  logic [INV_AREA_W-1:0]          tri_inv_area,
    output logic                           tri_stall,
    output logic                           overflow,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PIX_W-1:0]               bbox_min_x,
    output logic [PIX_W-1:0]               bbox_max_x,
    output logic [PIX_W-1:0]               bbox_min_y,
    output logic [PIX_W-1:0]               bbox_max_y,
    output logic [2:0][EDGE_AB_W-1:0]      edge_a,
    output logic [2:0][EDGE_AB_W-1:0]      edge_b,
    output logic [2:0][EDGE_C_W-1:0]       edge_c,
    output logic [2:0][Z_W-1:0]            out_z,
    output logic [2:0][COLOR_W-1:0]        out_color,
    output logic [INV_AREA_W-1:0]          out_inv_area,
    output logic [15:0]                    culled_count
);
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [BOX_W-1:0] MAX_X = BOX_W'(SCREEN_W - 1);
    localparam logic [BOX_W-1:0] MAX_Y = BOX_W'(SCREEN_H - 1);
    localparam logic [BOX_W-1:0] ROUND = BOX_W'((1 << COORD_FRAC) - 1);

    tri_entry_t        in_entry, head;
    logic [CNT_W-1:0]  q_count;
    logic              q_full, q_empty, pop;

    setup_state_e                 state_q;
    logic                         out_valid_q, overflow_q;
    logic [PIX_W-1:0]             min_x_q, max_x_q, min_y_q, max_y_q;
    logic [2:0][EDGE_AB_W-1:0]    edge_a_q, edge_b_q;
    logic [2:0][EDGE_C_W-1:0]     edge_c_q;
    logic [2:0][Z_W-1:0]          z_q;
    logic [2:0][COLOR_W-1:0]      color_q;
    logic [INV_AREA_W-1:0]        inv_area_q;
    logic [15:0]                  culled_q;

    assign in_entry = '{x: tri_x, y: tri_y, z: tri_z, color: tri_color, inv_area: tri_inv_area};

    tri_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tri_valid),
        .din_i   (in_entry),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign tri_stall = (q_count >= CNT_W'(DEPTH - 1));

    // Bounding box: floor of min, ceiling of max, with only the max clamped to the screen.
    logic [BOX_W-1:0] min_x_d, min_y_d, max_x_raw, max_y_raw, max_x_d, max_y_d;
    logic             cull;

    always_comb begin
        min_x_d   = BOX_W'(min3(head.x)) >> COORD_FRAC;
        min_y_d   = BOX_W'(min3(head.y)) >> COORD_FRAC;
        max_x_raw = (BOX_W'(max3(head.x)) + ROUND) >> COORD_FRAC;
        max_y_raw = (BOX_W'(max3(head.y)) + ROUND) >> COORD_FRAC;
        max_x_d   = (max_x_raw > MAX_X) ? MAX_X : max_x_raw;
        max_y_d   = (max_y_raw > MAX_Y) ? MAX_Y : max_y_raw;
        cull      = (min_x_d > max_x_d) || (min_y_d > max_y_d);
    end

    // Edge i pairs vertices (i+1)%3 and (i+2)%3. One edge is computed per cycle.
    logic [1:0]            eidx, vj, vk;
    logic [COORD_W-1:0]    xj, xk, yj, yk;
    logic [PROD_W-1:0]     prod_jk, prod_kj;
    logic [EDGE_AB_W-1:0]  a_d, b_d;
    logic [EDGE_C_W-1:0]   c_d;

    always_comb begin
        eidx = 2'd0;
        vj   = 2'd1;
        vk   = 2'd2;
        if (state_q == ST_E1) begin
            eidx = 2'd1;
            vj   = 2'd2;
            vk   = 2'd0;
        end else if (state_q == ST_E2) begin
            eidx = 2'd2;
            vj   = 2'd0;
            vk   = 2'd1;
        end
        xj      = head.x[vj];
        xk      = head.x[vk];
        yj      = head.y[vj];
        yk      = head.y[vk];
        prod_jk = PROD_W'(xj) * PROD_W'(yk);
        prod_kj = PROD_W'(xk) * PROD_W'(yj);
        a_d     = {1'b0, yj} - {1'b0, yk};
        b_d     = {1'b0, xk} - {1'b0, xj};
        c_d     = {1'b0, prod_jk} - {1'b0, prod_kj};
    end

    assign pop = ((state_q == ST_BBOX) && cull) || ((state_q == ST_EMIT) && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            min_x_q     <= '0;
            max_x_q     <= '0;
            min_y_q     <= '0;
            max_y_q     <= '0;
            edge_a_q    <= '0;
            edge_b_q    <= '0;
            edge_c_q    <= '0;
            z_q         <= '0;
            color_q     <= '0;
            inv_area_q  <= '0;
            culled_q    <= '0;
        end else begin
            if (tri_valid && q_full) overflow_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (!q_empty) state_q <= ST_BBOX;
                ST_BBOX: begin
                    if (cull) begin
                        culled_q <= culled_q + 16'd1;
                        state_q  <= ST_IDLE;
                    end else begin
                        min_x_q    <= PIX_W'(min_x_d);
                        max_x_q    <= PIX_W'(max_x_d);
                        min_y_q    <= PIX_W'(min_y_d);
                        max_y_q    <= PIX_W'(max_y_d);
                        z_q        <= head.z;
                        color_q    <= head.color;
                        inv_area_q <= head.inv_area;
                        state_q    <= ST_E0;
                    end
                end
                ST_E0, ST_E1, ST_E2: begin
                    edge_a_q[eidx] <= a_d;
                    edge_b_q[eidx] <= b_d;
                    edge_c_q[eidx] <= c_d;
                    if (state_q == ST_E0)      state_q <= ST_E1;
                    else if (state_q == ST_E1) state_q <= ST_E2;
                    else begin
                        state_q     <= ST_EMIT;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign overflow     = overflow_q;
    assign bbox_min_x   = min_x_q;
    assign bbox_max_x   = max_x_q;
    assign bbox_min_y   = min_y_q;
    assign bbox_max_y   = max_y_q;
    assign edge_a       = edge_a_q;
    assign edge_b       = edge_b_q;
    assign edge_c       = edge_c_q;
    assign out_z        = z_q;
    assign out_color    = color_q;
    assign out_inv_area = inv_area_q;
    assign culled_count = culled_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Bench for triangle_setup: a queue-and-service-timer reference model checked every cycle,
// directed cases with hand-computed values, then randomized traffic.
module tb_triangle_setup;
    import gpu_pkg::*;

    localparam int DEPTH = 2;
    localparam int SW    = 640;
    localparam int SH    = 480;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       tri_valid = 1'b0;
    logic [2:0][15:0]           tri_x = '0, tri_y = '0;
    logic [2:0][24:0]           tri_z = '0;
    logic [2:0][31:0]           tri_color = '0;
    logic [15:0]                tri_inv_area = '0;
    logic                       tri_stall, overflow, out_valid;
    logic                       out_ready = 1'b0;
    logic [9:0]                 bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
    logic [2:0][16:0]           edge_a, edge_b;
    logic [2:0][32:0]           edge_c;
    logic [2:0][24:0]           out_z;
    logic [2:0][31:0]           out_color;
    logic [15:0]                out_inv_area;
    logic [15:0]                culled_count;

    triangle_setup #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid),
        .tri_x(tri_x), .tri_y(tri_y), .tri_z(tri_z), .tri_color(tri_color),
        .tri_inv_area(tri_inv_area), .tri_stall(tri_stall), .overflow(overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c),
        .out_z(out_z), .out_color(out_color), .out_inv_area(out_inv_area),
        .culled_count(culled_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic int lo_px(input logic [2:0][15:0] v);
        int m = v[0];
        if (int'(v[1]) < m) m = v[1];
        if (int'(v[2]) < m) m = v[2];
        return m / 16;
    endfunction

    function automatic int hi_px(input logic [2:0][15:0] v, input int lim);
        int m = v[0];
        int h;
        if (int'(v[1]) > m) m = v[1];
        if (int'(v[2]) > m) m = v[2];
        h = (m + 15) / 16;
        return (h > lim - 1) ? lim - 1 : h;
    endfunction

    function automatic bit is_culled(input tri_entry_t t);
        return (lo_px(t.x) > hi_px(t.x, SW)) || (lo_px(t.y) > hi_px(t.y, SH));
    endfunction

    // which: 0 = A, 1 = B, 2 = C
    function automatic longint edge_val(input tri_entry_t t, input int i, input int which);
        int j = (i + 1) % 3;
        int k = (i + 2) % 3;
        longint xj = t.x[j], xk = t.x[k], yj = t.y[j], yk = t.y[k];
        if (which == 0) return yj - yk;
        if (which == 1) return xk - xj;
        return xj * yk - xk * yj;
    endfunction

    // Service index of the head triangle: 1 = seen while idle, 2 = box decision,
    // 3..5 = edges, 6 = result presented until accepted. 0 = nothing to do.
    tri_entry_t mq[$];
    int         svc = 0;
    bit         m_ovf = 0;
    int         m_culled = 0;
    int         delivered = 0;

    function automatic int eff();
        if (svc > 0) return svc;
        return (mq.size() > 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            svc      = 0;
            m_ovf    = 0;
            m_culled = 0;
        end else begin : mdl
            int e, sz;
            bit popped;
            e      = eff();
            sz     = mq.size();
            popped = 0;
            if (e == 2 && is_culled(mq[0])) begin
                popped = 1;
                m_culled++;
                svc = 0;
            end else if (e >= 6 && out_ready) begin
                popped = 1;
                delivered++;
                svc = 0;
            end else if (e > 0) begin
                svc = (e + 1 > 6) ? 6 : e + 1;
            end else begin
                svc = 0;
            end
            if (tri_valid) begin
                if (sz < DEPTH)
                    mq.push_back('{x: tri_x, y: tri_y, z: tri_z, color: tri_color, inv_area: tri_inv_area});
                else
                    m_ovf = 1;
            end
            if (popped) void'(mq.pop_front());
        end
    end

    always @(negedge clk) begin : cmp
        int e;
        e = eff();
        chk("out_valid", out_valid, (e >= 6) ? 1 : 0);
        chk("tri_stall", tri_stall, (mq.size() >= DEPTH - 1) ? 1 : 0);
        chk("overflow", overflow, m_ovf);
        chk("culled_count", culled_count, m_culled & 16'hFFFF);
        if (e >= 6) begin
            chk("bbox_min_x", bbox_min_x, lo_px(mq[0].x));
            chk("bbox_max_x", bbox_max_x, hi_px(mq[0].x, SW));
            chk("bbox_min_y", bbox_min_y, lo_px(mq[0].y));
            chk("bbox_max_y", bbox_max_y, hi_px(mq[0].y, SH));
            for (int i = 0; i < 3; i++) begin
                chk("edge_a", longint'($signed(edge_a[i])), edge_val(mq[0], i, 0));
                chk("edge_b", longint'($signed(edge_b[i])), edge_val(mq[0], i, 1));
                chk("edge_c", longint'($signed(edge_c[i])), edge_val(mq[0], i, 2));
                chk("out_z", out_z[i], mq[0].z[i]);
                chk("out_color", out_color[i], mq[0].color[i]);
            end
            chk("out_inv_area", out_inv_area, mq[0].inv_area);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_tri(input logic [15:0] x0, y0, x1, y1, x2, y2);
        tri_x = {x2, x1, x0};
        tri_y = {y2, y1, y0};
        for (int i = 0; i < 3; i++) begin
            tri_z[i]     = 25'($urandom);
            tri_color[i] = $urandom;
        end
        tri_inv_area = 16'($urandom);
    endtask

    task automatic send(input logic [15:0] x0, y0, x1, y1, x2, y2);
        set_tri(x0, y0, x1, y1, x2, y2);
        tri_valid = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
    endtask

    // Returns the number of clock edges, counting the capture edge, until out_valid is seen.
    task automatic wait_out(output int lat);
        int n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("wait_out_timeout", 0, 1);
        lat = n + 1;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic idle_no_valid(input int cycles, input string nm);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        int lat, d0;
        logic [15:0] rx [6];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", tri_stall, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_culled", culled_count, 0);
        chk("rst_bbox_max_x", bbox_max_x, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Right triangle spanning pixels 0..10.
        send(16'd0, 16'd0, 16'd160, 16'd0, 16'd0, 16'd160);
        wait_out(lat);
        chk("latency", lat, 6);
        chk("t1_min_x", bbox_min_x, 0);
        chk("t1_max_x", bbox_max_x, 10);
        chk("t1_min_y", bbox_min_y, 0);
        chk("t1_max_y", bbox_max_y, 10);
        chk("t1_edge_a0", longint'($signed(edge_a[0])), -160);
        chk("t1_edge_b0", longint'($signed(edge_b[0])), -160);
        chk("t1_edge_c0", longint'($signed(edge_c[0])), 25600);
        accept();

        // X beyond the screen clamps to the last column.
        send(16'd0, 16'd0, 16'h3000, 16'd0, 16'd0, 16'h0100);
        wait_out(lat);
        chk("clamp_max_x", bbox_max_x, 639);
        chk("clamp_min_x", bbox_min_x, 0);
        chk("clamp_max_y", bbox_max_y, 16);
        accept();

        // Entirely off-screen to the right: culled, nothing emitted.
        send(16'h2800, 16'd0, 16'h2900, 16'h0100, 16'h3000, 16'h0010);
        idle_no_valid(10, "cull_no_valid");
        chk("cull_count", culled_count, 1);

        // Back-pressure with a two-entry queue.
        d0 = delivered;
        send(16'd0, 16'd0, 16'd16, 16'd0, 16'd0, 16'd16);
        send(16'd0, 16'd0, 16'd32, 16'd0, 16'd0, 16'd16);
        chk("bp_stall", tri_stall, 1);
        chk("bp_no_ovf_yet", overflow, 0);
        send(16'd0, 16'd0, 16'd48, 16'd0, 16'd0, 16'd16);
        chk("bp_overflow", overflow, 1);
        wait_out(lat);
        chk("bp_first_max_x", bbox_max_x, 1);
        accept();
        wait_out(lat);
        chk("bp_second_max_x", bbox_max_x, 2);
        accept();
        idle_no_valid(12, "bp_no_third");
        chk("bp_delivered", delivered - d0, 2);

        // Fractional vertices: floor 1.5 -> 1, ceiling 3.5 -> 4.
        send(16'h0018, 16'd0, 16'h0038, 16'd0, 16'h0018, 16'h0020);
        wait_out(lat);
        chk("frac_min_x", bbox_min_x, 1);
        chk("frac_max_x", bbox_max_x, 4);
        chk("frac_max_y", bbox_max_y, 2);
        accept();

        // Reset while the second edge is being computed.
        send(16'h0020, 16'h0020, 16'h0200, 16'h0040, 16'h0080, 16'h0300);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_stall", tri_stall, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_culled", culled_count, 0);
        chk("mrst_bbox_max_x", bbox_max_x, 0);
        chk("mrst_edge_a0", edge_a[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h0010, 16'h0010, 16'h00A0, 16'h0010, 16'h0010, 16'h00A0);
        wait_out(lat);
        chk("post_rst_latency", lat, 6);
        chk("post_rst_max_x", bbox_max_x, 10);
        accept();

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int v = 0; v < 6; v++) begin
                if ($urandom_range(0, 9) == 0) rx[v] = 16'($urandom);
                else if (v % 2 == 0)           rx[v] = 16'($urandom_range(0, 16'h2C00));
                else                           rx[v] = 16'($urandom_range(0, 16'h2000));
            end
            set_tri(rx[0], rx[1], rx[2], rx[3], rx[4], rx[5]);
            tri_valid = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        tri_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
